// File: rtl/cpu_obi_arb_pkg.sv
// Shared types for the CPU instruction/data OBI port arbiter.
package cpu_obi_arb_pkg;

  typedef enum logic {
    ARB_INSTR = 1'b0,
    ARB_DATA  = 1'b1
  } arb_id_e;

  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

  function automatic arb_id_e arb_other(input arb_id_e id);
    return (id == ARB_INSTR) ? ARB_DATA : ARB_INSTR;
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response payloads for the 32-bit CPU bus.
package obi_pkg;

  localparam int unsigned OBI_AW = 32;
  localparam int unsigned OBI_DW = 32;
  localparam int unsigned OBI_BW = OBI_DW / 8;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [OBI_BW-1:0] be;
    logic [OBI_AW-1:0] addr;
    logic [OBI_DW-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [OBI_DW-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/cpu_obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for transactions awaiting rvalid.
module cpu_obi_arb_id_fifo
  import cpu_obi_arb_pkg::*;
#(
  parameter int unsigned  DEPTH = DEFAULT_MAX_OUTSTANDING,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  arb_id_e          push_id_i,
  input  logic             pop_i,
  output arb_id_e          head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  arb_id_e          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_en;
  logic             pop_en;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= ARB_INSTR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cpu_obi_port_arbiter.sv
// 2:1 arbiter merging the CPU instruction and data OBI ports onto one master port.
// Define CPU_OBI_ARB_PERF_CNT_EN to add the conflict_cnt_o contention counter.
module cpu_obi_port_arbiter
  import obi_pkg::*;
  import cpu_obi_arb_pkg::*;
#(
  parameter int unsigned  MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    instr_req_i,
  output obi_resp_t   instr_resp_o,
  input  obi_req_t    data_req_i,
  output obi_resp_t   data_resp_o,
  output obi_req_t    mem_req_o,
  input  obi_resp_t   mem_resp_i
`ifdef CPU_OBI_ARB_PERF_CNT_EN
  ,
  output logic [31:0] conflict_cnt_o
`endif
);

  arb_id_e          sel_c;
  arb_id_e          head_id;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             hs_c;
  logic             spurious_rvalid_c;

  logic             lock_valid_q;
  logic             lock_valid_d;
  arb_id_e          lock_id_q;
  arb_id_e          lock_id_d;
  arb_id_e          prio_q;
  arb_id_e          prio_d;

  // A held lock wins; otherwise a lone requester, otherwise the round-robin pointer.
  always_comb begin
    sel_c = prio_q;
    if (lock_valid_q)                              sel_c = lock_id_q;
    else if (instr_req_i.req && !data_req_i.req)   sel_c = ARB_INSTR;
    else if (data_req_i.req && !instr_req_i.req)   sel_c = ARB_DATA;
  end

  always_comb begin
    mem_req_o = (sel_c == ARB_DATA) ? data_req_i : instr_req_i;
    if (fifo_full && !lock_valid_q) mem_req_o.req = 1'b0;
  end

  assign hs_c              = mem_req_o.req & mem_resp_i.gnt;
  assign spurious_rvalid_c = mem_resp_i.rvalid & fifo_empty;

  // Responses go to whichever port owns the oldest outstanding transaction.
  always_comb begin
    instr_resp_o        = '0;
    data_resp_o         = '0;
    instr_resp_o.gnt    = hs_c & (sel_c == ARB_INSTR);
    data_resp_o.gnt     = hs_c & (sel_c == ARB_DATA);
    instr_resp_o.rvalid = mem_resp_i.rvalid & ~fifo_empty & (head_id == ARB_INSTR);
    data_resp_o.rvalid  = mem_resp_i.rvalid & ~fifo_empty & (head_id == ARB_DATA);
    instr_resp_o.rdata  = mem_resp_i.rdata;
    data_resp_o.rdata   = mem_resp_i.rdata;
  end

  always_comb begin
    lock_valid_d = mem_req_o.req & ~mem_resp_i.gnt;
    lock_id_d    = sel_c;
    prio_d       = hs_c ? arb_other(sel_c) : prio_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= ARB_INSTR;
      prio_q       <= ARB_INSTR;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      prio_q       <= prio_d;
    end
  end

  cpu_obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (hs_c),
    .push_id_i (sel_c),
    .pop_i     (mem_resp_i.rvalid),
    .head_o    (head_id),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

`ifdef CPU_OBI_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q;
  logic        conflict_c;

  // Both ports want the bus and one of them is being issued or held by the lock.
  assign conflict_c = instr_req_i.req & data_req_i.req & mem_req_o.req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                     conflict_cnt_q <= '0;
    else if (conflict_c && (conflict_cnt_q != '1))   conflict_cnt_q <= conflict_cnt_q + 32'd1;
  end

  assign conflict_cnt_o = conflict_cnt_q;
`endif

`ifndef SYNTHESIS
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_req_o.req && !mem_resp_i.gnt) |=> (mem_req_o == $past(mem_req_o)))
    else $error("mem request changed while waiting for grant");

  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_count <= CNT_W'(MAX_OUTSTANDING))
    else $error("outstanding count above limit");

  a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !spurious_rvalid_c)
    else $warning("rvalid with no outstanding transaction, response dropped");
`endif

endmodule

// File: tb/tb_cpu_obi_port_arbiter.sv
// Bench for cpu_obi_port_arbiter: directed vector table, queue-based reference model, random traffic.
module tb_cpu_obi_port_arbiter;
  import obi_pkg::*;
  import cpu_obi_arb_pkg::*;

  localparam int unsigned MAX    = 2;
  localparam logic [31:0] I_ADDR = 32'h0000_0180;
  localparam logic [31:0] D_ADDR = 32'h0000_1000;
  localparam obi_req_t    I_REQ  = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: I_ADDR, wdata: 32'h0};
  localparam obi_req_t    D_REQ  = '{req: 1'b1, we: 1'b1, be: 4'h3, addr: D_ADDR, wdata: 32'hDEAD_BEEF};
  localparam obi_req_t    IDLE   = '0;
  localparam int          NV     = 15;

  logic      clk = 1'b0;
  logic      rst_n;
  obi_req_t  ireq, dreq, mreq;
  obi_resp_t iresp, dresp, mresp;
`ifdef CPU_OBI_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt;
`endif

  cpu_obi_port_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .instr_req_i  (ireq),
    .instr_resp_o (iresp),
    .data_req_i   (dreq),
    .data_resp_o  (dresp),
    .mem_req_o    (mreq),
    .mem_resp_i   (mresp)
`ifdef CPU_OBI_ARB_PERF_CNT_EN
    ,
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // stim = {instr req, data req, gnt, rvalid}; exp = {mem req, instr gnt, data gnt, instr rvalid, data rvalid}
  typedef struct {
    logic [3:0]  stim;
    logic [31:0] rdata;
    logic [4:0]  exp;
    logic [31:0] addr;
  } vec_t;

  // Reference model state: in-order queue of outstanding owners (0 = instr, 1 = data).
  bit mq[$];
  bit m_prio, m_lock_v, m_lock_id;
  bit m_gi, m_gd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_prio = 1'b0; m_lock_v = 1'b0; m_lock_id = 1'b0; m_gi = 1'b0; m_gd = 1'b0;
  endtask

  // Asserts reset at a falling edge (possibly mid-traffic), checks quiet outputs, releases.
  task automatic do_reset();
    @(negedge clk);
    ireq = '0; dreq = '0; mresp = '0;
    rst_n = 1'b0;
    #1;
    chk("reset.mem_req",    128'(mreq),  128'(0));
    chk("reset.instr_resp", 128'(iresp), 128'(0));
    chk("reset.data_resp",  128'(dresp), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic apply_vec(input int k, input vec_t v);
    ireq = I_REQ; ireq.req = v.stim[3];
    dreq = D_REQ; dreq.req = v.stim[2];
    mresp.gnt = v.stim[1]; mresp.rvalid = v.stim[0]; mresp.rdata = v.rdata;
    #1;
    chk($sformatf("vec%0d.mem_req", k), 128'(mreq.req), 128'(v.exp[4]));
    if (v.exp[4])
      chk($sformatf("vec%0d.mem_fields", k), 128'(mreq), 128'((v.addr == I_ADDR) ? I_REQ : D_REQ));
    chk($sformatf("vec%0d.instr_gnt", k),    128'(iresp.gnt),    128'(v.exp[3]));
    chk($sformatf("vec%0d.data_gnt", k),     128'(dresp.gnt),    128'(v.exp[2]));
    chk($sformatf("vec%0d.instr_rvalid", k), 128'(iresp.rvalid), 128'(v.exp[1]));
    chk($sformatf("vec%0d.data_rvalid", k),  128'(dresp.rvalid), 128'(v.exp[0]));
    chk($sformatf("vec%0d.rdata", k),        128'({iresp.rdata, dresp.rdata}), 128'({v.rdata, v.rdata}));
    @(negedge clk);
  endtask

  // One cycle checked against the model, then the model advances with the clock edge.
  task automatic mcycle(input obi_req_t ri, input obi_req_t rd, input logic g, input logic rv,
                        input logic [31:0] rdat);
    bit       sel, issue, e_irv, e_drv;
    obi_req_t exp;
    ireq = ri; dreq = rd;
    mresp.gnt = g; mresp.rvalid = rv; mresp.rdata = rdat;
    if (m_lock_v)                sel = m_lock_id;
    else if (ri.req && !rd.req)  sel = 1'b0;
    else if (rd.req && !ri.req)  sel = 1'b1;
    else                         sel = m_prio;
    exp   = sel ? rd : ri;
    issue = exp.req && (m_lock_v || (mq.size() < MAX));
    e_irv = rv && (mq.size() > 0) && (mq[0] == 1'b0);
    e_drv = rv && (mq.size() > 0) && (mq[0] == 1'b1);
    m_gi  = issue && g && !sel;
    m_gd  = issue && g && sel;
    #1;
    chk("model.mem_req", 128'(mreq.req), 128'(issue));
    if (issue) chk("model.mem_fields", 128'(mreq), 128'(exp));
    chk("model.instr_gnt",    128'(iresp.gnt),    128'(m_gi));
    chk("model.data_gnt",     128'(dresp.gnt),    128'(m_gd));
    chk("model.instr_rvalid", 128'(iresp.rvalid), 128'(e_irv));
    chk("model.data_rvalid",  128'(dresp.rvalid), 128'(e_drv));
    chk("model.rdata",        128'({iresp.rdata, dresp.rdata}), 128'({rdat, rdat}));
    if (rv && (mq.size() > 0)) void'(mq.pop_front());
    if (issue && g) begin
      mq.push_back(sel);
      m_prio = !sel;
    end
    m_lock_v  = issue && !g;
    m_lock_id = sel;
    @(negedge clk);
  endtask

  function automatic obi_req_t rand_req();
    obi_req_t r;
    r.req   = ($urandom_range(2) != 0);
    r.we    = 1'($urandom);
    r.be    = 4'($urandom);
    r.addr  = $urandom;
    r.wdata = $urandom;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t     vecs [NV];
    obi_req_t cur_i, cur_d;

    vecs[0]  = '{4'b1110, 32'h0,    5'b11000, I_ADDR};
    vecs[1]  = '{4'b1111, 32'hAAAA, 5'b10110, D_ADDR};
    vecs[2]  = '{4'b1111, 32'h5555, 5'b11001, I_ADDR};
    vecs[3]  = '{4'b1111, 32'hAAAA, 5'b10110, D_ADDR};
    vecs[4]  = '{4'b0001, 32'h5555, 5'b00001, 32'h0};
    vecs[5]  = '{4'b0100, 32'h0,    5'b10000, D_ADDR};
    vecs[6]  = '{4'b1100, 32'h0,    5'b10000, D_ADDR};
    vecs[7]  = '{4'b1100, 32'h0,    5'b10000, D_ADDR};
    vecs[8]  = '{4'b1110, 32'h0,    5'b10100, D_ADDR};
    vecs[9]  = '{4'b1010, 32'h0,    5'b11000, I_ADDR};
    vecs[10] = '{4'b0110, 32'h0,    5'b00000, 32'h0};
    vecs[11] = '{4'b0111, 32'h5555, 5'b00001, 32'h0};
    vecs[12] = '{4'b0110, 32'h0,    5'b10100, D_ADDR};
    vecs[13] = '{4'b0001, 32'hAAAA, 5'b00010, 32'h0};
    vecs[14] = '{4'b0001, 32'h5555, 5'b00001, 32'h0};

    rst_n = 1'b1; ireq = '0; dreq = '0; mresp = '0;
    model_clear();

    // Contention round-robin, lock hold, full stall, in-order routing.
    do_reset();
    for (int k = 0; k < NV; k++) apply_vec(k, vecs[k]);

    // Back-to-back handshake plus rvalid at one outstanding, wrapping the ID FIFO.
    do_reset();
    mcycle(I_REQ, D_REQ, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 10; k++) mcycle(I_REQ, D_REQ, 1'b1, 1'b1, $urandom);
    mcycle(IDLE, IDLE, 1'b0, 1'b1, $urandom);

    // Random OBI-compliant traffic: requests held until granted, rvalid only when owed.
    do_reset();
    cur_i = '0; cur_d = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!cur_i.req || m_gi) cur_i = rand_req();
      if (!cur_d.req || m_gd) cur_d = rand_req();
      mcycle(cur_i, cur_d, ($urandom_range(3) != 0),
             (mq.size() > 0) && ($urandom_range(2) != 0), $urandom);
    end

    // Reset with two outstanding, then a spurious response must be dropped.
    do_reset();
    mcycle(I_REQ, IDLE, 1'b1, 1'b0, 32'h0);
    mcycle(I_REQ, IDLE, 1'b1, 1'b0, 32'h0);
    do_reset();
    ireq = '0; dreq = '0;
    mresp.gnt = 1'b0; mresp.rvalid = 1'b1; mresp.rdata = 32'h1234;
    #1;
    chk("spurious.instr_rvalid", 128'(iresp.rvalid), 128'(0));
    chk("spurious.data_rvalid",  128'(dresp.rvalid), 128'(0));
    chk("spurious.flag",         128'(dut.spurious_rvalid_c), 128'(1));
    @(negedge clk);
    mcycle(I_REQ, IDLE, 1'b1, 1'b0, 32'h0);
    mcycle(IDLE, D_REQ, 1'b1, 1'b0, 32'h0);
    mcycle(I_REQ, D_REQ, 1'b1, 1'b0, 32'h0);

`ifdef CPU_OBI_ARB_PERF_CNT_EN
    // Five cycles of both ports requesting while the issued one waits for grant.
    do_reset();
    chk("perf.reset", 128'(conflict_cnt), 128'(0));
    for (int k = 0; k < 5; k++) mcycle(I_REQ, D_REQ, 1'b0, 1'b0, 32'h0);
    chk("perf.count", 128'(conflict_cnt), 128'(5));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
